dcache_to_mem_converter: RTL



---
 rtl/mpt_pkg.sv | 48 ++++
 rtl/dcache_to_mem_converter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mpt_pkg.sv
// Shared MEM-side helpers: D$ port structs, converter FSM state encoding and
// the {tag,index} address packing used by D$-to-MEM converters.
package mpt_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 20;
    localparam int unsigned DCACHE_TID_WIDTH   = 4;
    localparam int unsigned DCACHE_USER_WIDTH  = 1;
    localparam int unsigned MEM_ADDR_PACK_WIDTH = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [XLEN-1:0]               data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [XLEN/8-1:0]             data_be;
        logic [DCACHE_TID_WIDTH-1:0]   data_id;
        logic                          kill_req;
        logic                          tag_valid;
    } dreq_i_t;

    typedef struct packed {
        logic                          data_gnt;
        logic                          data_rvalid;
        logic [DCACHE_TID_WIDTH-1:0]   data_rid;
        logic [XLEN-1:0]               data_rdata;
        logic [DCACHE_USER_WIDTH-1:0]  data_ruser;
    } dresp_o_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TAG,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } conv_state_e;

    // Byte address seen by the MEM slave; callers resize to their bus width.
    function automatic logic [MEM_ADDR_PACK_WIDTH-1:0] pack_mem_addr(
        input logic [DCACHE_TAG_WIDTH-1:0]   tag,
        input logic [DCACHE_INDEX_WIDTH-1:0] index
    );
        return {tag, index};
    endfunction

endpackage

// File: rtl/dcache_to_mem_converter.sv
// Single-outstanding bridge from a D$ request port to a MEM-protocol master,
// with split index/tag phases, kill/flush abort and response suppression.
module dcache_to_mem_converter
    import mpt_pkg::*;
#(
    parameter type         dcache_req_i_t = mpt_pkg::dreq_i_t,
    parameter type         dcache_req_o_t = mpt_pkg::dresp_o_t,
    parameter int unsigned DATA_WIDTH     = XLEN
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  dcache_req_i_t           req_port_i,
    output dcache_req_o_t           req_port_o,
    output logic                    m_mem_req,
    input  logic                    m_mem_gnt,
    input  logic                    m_mem_valid,
    output logic [DATA_WIDTH-1:0]   m_mem_addr,
    input  logic [DATA_WIDTH-1:0]   m_mem_rdata,
    output logic [DATA_WIDTH-1:0]   m_mem_wdata,
    output logic                    m_mem_we,
    output logic [DATA_WIDTH/8-1:0] m_mem_be,
    input  logic                    m_mem_error,
    output logic                    mem_error_o,
    output logic                    busy_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    conv_state_e state_reg, state_next;

    logic [DCACHE_INDEX_WIDTH-1:0] index_reg;
    logic [DCACHE_TAG_WIDTH-1:0]   tag_reg;
    logic [XLEN-1:0]               wdata_reg;
    logic [XLEN/8-1:0]             be_reg;
    logic                          we_reg;
    logic [DCACHE_TID_WIDTH-1:0]   id_reg;
    logic [DATA_WIDTH-1:0]         rdata_reg;
    logic                          err_reg;
    logic                          drop_reg;

    logic gnt;
    logic capture;
    logic tag_latch;
    logic resp_latch;
    logic drop_set;
    logic in_mem_req;

    always_comb begin
        state_next = state_reg;
        gnt        = 1'b0;
        capture    = 1'b0;
        tag_latch  = 1'b0;
        resp_latch = 1'b0;
        drop_set   = 1'b0;
        in_mem_req = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by reset so the port is fully quiet while held in reset.
                gnt = req_port_i.data_req & ~flush_i & rst_ni;
                if (gnt) begin
                    capture = 1'b1;
                    if (req_port_i.data_we) begin
                        tag_latch  = 1'b1;
                        state_next = MEM_REQ;
                    end else begin
                        state_next = WAIT_TAG;
                    end
                end
            end
            WAIT_TAG: begin
                if (req_port_i.kill_req || flush_i) begin
                    state_next = IDLE;
                end else if (req_port_i.tag_valid) begin
                    tag_latch  = 1'b1;
                    state_next = MEM_REQ;
                end
            end
            MEM_REQ: begin
                in_mem_req = 1'b1;
                drop_set   = flush_i;
                if (m_mem_gnt) begin
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                drop_set = flush_i;
                if (m_mem_valid) begin
                    resp_latch = 1'b1;
                    // A flush arriving with the response still suppresses it.
                    if (!we_reg && !(drop_reg || flush_i)) begin
                        state_next = RESP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            index_reg <= '0;
            tag_reg   <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            we_reg    <= 1'b0;
            id_reg    <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                index_reg <= req_port_i.address_index;
                wdata_reg <= req_port_i.data_wdata;
                be_reg    <= req_port_i.data_be;
                we_reg    <= req_port_i.data_we;
                id_reg    <= req_port_i.data_id;
            end
            if (tag_latch) begin
                tag_reg <= req_port_i.address_tag;
            end
            if (resp_latch) begin
                rdata_reg <= m_mem_rdata;
                err_reg   <= m_mem_error;
            end
            if (state_next == IDLE) begin
                drop_reg <= 1'b0;
            end else if (drop_set) begin
                drop_reg <= 1'b1;
            end
        end
    end

    // MEM-side fields are only driven while the request is presented.
    always_comb begin
        m_mem_req   = in_mem_req;
        m_mem_addr  = '0;
        m_mem_wdata = '0;
        m_mem_we    = 1'b0;
        m_mem_be    = '0;
        if (in_mem_req) begin
            m_mem_addr  = DATA_WIDTH'(pack_mem_addr(tag_reg, index_reg));
            m_mem_wdata = DATA_WIDTH'(wdata_reg);
            m_mem_we    = we_reg;
            m_mem_be    = BE_WIDTH'(be_reg);
        end
    end

    always_comb begin
        req_port_o             = '0;
        req_port_o.data_gnt    = gnt;
        req_port_o.data_rvalid = (state_reg == RESP);
        req_port_o.data_rid    = id_reg;
        req_port_o.data_rdata  = XLEN'(rdata_reg);
    end

    assign mem_error_o = (state_reg == RESP) & err_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule
